// File: rtl/regfile_wb_pkg.sv
// Shared widths and the writeback request record used by the register-file
// write-port arbiter and its load buffer.
package regfile_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests.
// Also exposes per-entry valid bits and addresses for the pending-register map.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  wb_req_t                       i_din,
    input  logic                          i_pop,
    output wb_req_t                       o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [DEPTH-1:0]              o_ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_ent_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [DEPTH-1:0] r_vld;
    wb_req_t          r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];
    assign o_ent_vld = r_vld;

    always_comb begin
        o_ent_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_addr[i] = r_mem[i].addr;
        end
    end

    // Push and pop can never target the same slot: pointers coincide only
    // when the FIFO is empty (no pop) or full (no push).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges single-cycle ALU results (priority) and buffered load results onto
// the single register-file write port; exports a pending-register bitmap.
module regfile_wb_arbiter #(
    parameter int DATA_W     = regfile_wb_pkg::DATA_W,
    parameter int ADDR_W     = regfile_wb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ZERO_DROP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 we,
    output logic [ADDR_W-1:0]    writeaddr,
    output logic [DATA_W-1:0]    writedata,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 busy
);

    import regfile_wb_pkg::*;

    localparam int NR = 2**ADDR_W;

    logic                                  w_full;
    logic                                  w_empty;
    logic                                  w_alu_wr;
    logic                                  w_ld_push;
    logic                                  w_pop;
    wb_req_t                               w_din;
    wb_req_t                               w_head;
    logic [FIFO_DEPTH-1:0]                 w_ent_vld;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]     w_ent_addr;

    logic              r_we;
    logic [ADDR_W-1:0] r_writeaddr;
    logic [DATA_W-1:0] r_writedata;

    // An ALU write must wait while an older buffered load targets the same
    // register, otherwise the load would later overwrite the younger value.
    assign alu_ready = !rst && !pending[alu_addr];
    assign ld_ready  = !rst && !w_full;

    // Handshakes to r0 still complete; they just leave no trace when dropping.
    assign w_alu_wr  = alu_valid && alu_ready && !((ZERO_DROP != 0) && (alu_addr == '0));
    assign w_ld_push = ld_valid && ld_ready && !((ZERO_DROP != 0) && (ld_addr == '0));
    assign w_pop     = !w_alu_wr && !w_empty;
    assign w_din     = '{addr: ld_addr, data: ld_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_ld_push),
        .i_din      (w_din),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_ent_vld  (w_ent_vld),
        .o_ent_addr (w_ent_addr)
    );

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_ent_vld[i]) begin
                pending[w_ent_addr[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_writeaddr <= '0;
            r_writedata <= '0;
        end else if (w_alu_wr) begin
            r_we        <= 1'b1;
            r_writeaddr <= alu_addr;
            r_writedata <= alu_data;
        end else if (w_pop) begin
            r_we        <= 1'b1;
            r_writeaddr <= w_head.addr;
            r_writedata <= w_head.data;
        end else begin
            r_we        <= 1'b0;
        end
    end

    assign we        = r_we;
    assign writeaddr = r_writeaddr;
    assign writedata = r_writedata;
    assign busy      = !w_empty || r_we;

endmodule
